// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for the bit-serial adder/subtractor.
// The master issues requests; the slave (serial_adder) returns results and status.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic             cin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    logic             busy;
    logic             done;

    modport master (
        output start, sub, cin, a, b,
        input  s, cout, ovf, busy, done
    );

    modport slave (
        input  start, sub, cin, a, b,
        output s, cout, ovf, busy, done
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell, one operand bit per clock,
// LSB first, with start/busy/done handshake and carry/overflow flags.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_adder_if.slave       bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_sh, b_sh, r_sh;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] s_q;
    logic             cout_q, ovf_q;

    logic sum, c_next, last_bit, accept;

    assign sum      = a_sh[0] ^ b_sh[0] ^ carry;
    assign c_next   = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));
    assign accept   = (state == IDLE) && bus.start;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: next_state gets its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (last_bit)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            r_sh   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            s_q    <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (accept) begin
            // Subtraction is a + ~b + 1: invert b once here and seed the carry.
            a_sh  <= bus.a;
            b_sh  <= bus.sub ? ~bus.b : bus.b;
            carry <= bus.sub ? 1'b1 : bus.cin;
            r_sh  <= '0;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            r_sh  <= {sum, r_sh[WIDTH-1:1]};
            carry <= c_next;
            cnt   <= cnt + 1'b1;
            if (last_bit) begin
                // On the MSB cycle 'carry' is the carry into the MSB.
                s_q    <= {sum, r_sh[WIDTH-1:1]};
                cout_q <= c_next;
                ovf_q  <= carry ^ c_next;
            end
        end
    end

    assign bus.s    = s_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
    assign bus.busy = (state != IDLE);
    assign bus.done = (state == DONE);
endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder at WIDTH=8.
module tb_serial_adder;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_total = 0;
    int   n_pass  = 0;

    serial_adder_if #(.WIDTH(WIDTH)) bus ();

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Presents a request for exactly one edge (E0); returns #1 after E0.
    task automatic launch(input logic [7:0] a, input logic [7:0] b,
                          input logic sub, input logic cin);
        bus.a     = a;
        bus.b     = b;
        bus.sub   = sub;
        bus.cin   = cin;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Counts edges after E0 until done is seen; 99 means it never came.
    task automatic wait_done(output int edges);
        edges = 99;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) begin
                edges = i;
                break;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic sub, input logic cin, input logic [7:0] exp_s,
                          input logic exp_c, input logic exp_o);
        int lat;
        launch(a, b, sub, cin);
        check({tag, " busy_after_start"}, 64'(bus.busy), 64'd1);
        wait_done(lat);
        check({tag, " latency"}, 64'(lat), 64'd8);
        check({tag, " s"}, 64'(bus.s), 64'(exp_s));
        check({tag, " cout"}, 64'(bus.cout), 64'(exp_c));
        check({tag, " ovf"}, 64'(bus.ovf), 64'(exp_o));
        @(posedge clk);
        #1;
        check({tag, " done_one_cycle"}, 64'(bus.done), 64'd0);
        check({tag, " busy_cleared"}, 64'(bus.busy), 64'd0);
        check({tag, " s_held"}, 64'(bus.s), 64'(exp_s));
    endtask

    initial begin
        int lat;
        int busy_cycles;
        int done_seen;

        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.cin   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        check("reset s",    64'(bus.s),    64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic add with explicit busy-length measurement.
        launch(8'h3C, 8'h05, 1'b0, 1'b0);
        busy_cycles = 1;
        lat = 99;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1 && lat == 99) lat = i;
            if (bus.busy !== 1'b1) break;
            busy_cycles++;
        end
        check("add latency", 64'(lat), 64'd8);
        check("add busy_cycles", 64'(busy_cycles), 64'd9);
        check("add s", 64'(bus.s), 64'h41);
        check("add cout", 64'(bus.cout), 64'd0);
        check("add ovf", 64'(bus.ovf), 64'd0);

        // Asynchronous reset between edges clears outputs immediately.
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst s",    64'(bus.s),    64'd0);
        check("async_rst cout", 64'(bus.cout), 64'd0);
        check("async_rst ovf",  64'(bus.ovf),  64'd0);
        check("async_rst busy", 64'(bus.busy), 64'd0);
        check("async_rst done", 64'(bus.done), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_op("add_carry",  8'hFF, 8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0);
        run_op("add_ovf",    8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        run_op("sub_borrow", 8'h10, 8'h20, 1'b1, 1'b0, 8'hF0, 1'b0, 1'b0);
        run_op("sub_ovf",    8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1);
        run_op("sub_cin",    8'h05, 8'h05, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0);

        // start during RUN and during DONE must be ignored.
        launch(8'h01, 8'h01, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        bus.a     = 8'hAA;
        bus.b     = 8'h55;
        bus.sub   = 1'b1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(lat);
        check("busyprot latency", 64'(lat), 64'd6);
        check("busyprot s", 64'(bus.s), 64'h02);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("busyprot busy_after_done", 64'(bus.busy), 64'd0);
        done_seen = 0;
        busy_cycles = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) done_seen++;
            if (bus.busy === 1'b1) busy_cycles++;
        end
        check("busyprot no_second_done", 64'(done_seen), 64'd0);
        check("busyprot no_second_op", 64'(busy_cycles), 64'd0);
        check("busyprot s_held", 64'(bus.s), 64'h02);

        // Reset after four RUN edges aborts with no done pulse.
        launch(8'h33, 8'h44, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst s",    64'(bus.s),    64'd0);
        check("midrst busy", 64'(bus.busy), 64'd0);
        check("midrst done", 64'(bus.done), 64'd0);
        done_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) done_seen++;
            if (i == 1) rst = 1'b0;
        end
        check("midrst no_done", 64'(done_seen), 64'd0);
        run_op("after_rst", 8'h20, 8'h22, 1'b0, 1'b0, 8'h42, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
